uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares the single chip UART transmitter between up to four on-chip byte sources (CPU bus slave, debug monitor, boot loader, spare). Arbitration is round-robin at byte granularity. A per-requester lock keeps ownership for a multi-byte message, so console strings never interleave. Sits between the requesters and uart_tx inside the UART subsystem, and drives uart_tx's start/data inputs.

Parameters:
REQ_NUM, 4, number of requesters (fixed at 4 this revision; all vectors sized from it)
MAX_BURST, 16, maximum bytes sent under one lock before forced release (1..255)
HOLD_TIMEOUT, 64, cycles an owner may hold the lock in HOLD without presenting a byte (1..255)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req  in  4  requester i has a byte on its data slice; held until ack[i]
lock  in  4  requester i wants to keep the grant after the current byte
data  in  32  byte for requester i at [8i+7:8i]
ack  out  4  one-cycle pulse: byte from requester i accepted
gnt  out  4  one-hot current owner; 0 when free
tx_start  out  1  one-cycle start pulse to uart_tx
tx_data  out  8  byte to uart_tx, valid in the tx_start cycle and stable until the next start
tx_busy  in  1  uart_tx transmitting
tx_end  in  1  uart_tx one-cycle completion pulse

Behaviour:
- All outputs are registered. Reset: gnt=0, ack=0, tx_start=0, tx_data=8'h00, state=IDLE, rr_ptr=0, burst_cnt=0, hold_timer=0.
- States: IDLE, SEND, HOLD.
- IDLE: if any req and tx_busy=0, the winner is the first set req at or after rr_ptr, circularly. At the next edge: gnt=onehot(winner), tx_data=data[winner], tx_start=1, ack[winner]=1, burst_cnt=0, state goes to SEND. Latency from req to tx_start is 1 cycle.
- If tx_busy=1 in IDLE, no grant is issued.
- SEND: wait for tx_end. On tx_end:
  - if lock[owner]=1 and burst_cnt<MAX_BURST-1: go to HOLD, hold_timer=0.
  - otherwise release: gnt=0, rr_ptr=owner+1 mod 4, go to IDLE.
  - req and lock changes during SEND are ignored.
- HOLD, evaluated in priority order:
  1. req[owner]=1: tx_start, ack[owner] and tx_data as above; burst_cnt+1; go to SEND.
  2. lock[owner]=0: release.
  3. hold_timer=HOLD_TIMEOUT-1: release.
  4. otherwise hold_timer+1.
- Other requesters are never served in SEND or HOLD.
- Requester contract: after ack, the requester deasserts req or presents the next byte before the following tx_end. Because of the SEND state, no second ack is possible within 2 cycles.
- Simultaneous requests: the rotating pointer guarantees each continuously requesting source is served within 3 grants of others.
- Reset mid-transfer returns to IDLE immediately. The byte already in uart_tx completes on the line; arbitration resumes only once tx_busy=0.
- tx_end seen in IDLE or HOLD is ignored.
- Counter widths: burst_cnt and hold_timer are 8 bits. Wrap is impossible because of the parameter ranges.

Optional Feature:
UART_ARB_STAT_EN
- Defined: adds outputs stat_cnt [63:0] (four 16-bit saturating per-requester byte counters, incremented on each ack) and stat_to [3:0] (sticky flag per requester, set on HOLD timeout release). Both are cleared by reset only.
- Undefined: these ports and their logic are absent, and the core behaviour is identical.

Decomposition:
- Shared header uart_arb.h holds:
  - state encodings UART_ARB_IDLE/SEND/HOLD and the state bus width;
  - requester index width and UART_ARB_REQ_NUM;
  - per-requester ID constants UART_ARB_ID_CPU, ID_DBG, ID_BOOT, ID_SPARE.
- One natural sub-module: uart_arb_rr_pick. It is combinational and takes req[3:0] and rr_ptr to produce a one-hot winner and a valid flag, so the fairness logic is unit-testable alone.

Test Plan:
- Single byte: req[1]=1, data[15:8]=8'h41, tx_busy=0 → next cycle tx_start=1, ack=4'b0010, tx_data=8'h41, gnt=4'b0010. After tx_end → gnt=0, rr_ptr=2.
- Round-robin: req=4'b1111 held and refreshed after each ack, rr_ptr=0 → grant order 0,1,2,3,0 over 5 bytes, one per tx_end.
- Locked burst: requester 2 holds lock=1 and sends "HELLO" while req[0] is also asserted → bytes 48 45 4C 4C 4F all from requester 2, then requester 0 is granted once lock drops.
- Burst cap: MAX_BURST=4, requester 3 locked with continuous data → exactly 4 acks to requester 3, then release. Requester 0 (pending) is granted next.
- Hold timeout: HOLD_TIMEOUT=8, owner keeps lock=1 with req=0 → release 8 cycles after entering HOLD, gnt=0, and stat_to[owner]=1 when UART_ARB_STAT_EN is defined.
- Reset mid-SEND and tx_busy gating: assert reset during SEND → all outputs 0 asynchronously. With tx_busy=1 after reset release and req[0]=1, there is no tx_start until tx_busy falls, then tx_start follows 1 cycle later.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg
// Shared definitions for the UART transmit arbiter:
//   - FSM state encoding (UART_ARB_IDLE / SEND / HOLD) and state bus width
//   - requester count, requester index width and counter widths
//   - fixed requester IDs (CPU bus slave, debug monitor, boot loader, spare)
//   - onehot_to_idx helper used to turn a one-hot grant into an index
package uart_arb_pkg;

  localparam int UART_ARB_REQ_NUM = 4;
  localparam int UART_ARB_IDX_W   = 2;
  localparam int UART_ARB_STATE_W = 2;
  localparam int UART_ARB_CNT_W   = 8;
  localparam int UART_ARB_STAT_W  = 16;

  localparam logic [UART_ARB_IDX_W-1:0] UART_ARB_ID_CPU   = 2'd0;
  localparam logic [UART_ARB_IDX_W-1:0] UART_ARB_ID_DBG   = 2'd1;
  localparam logic [UART_ARB_IDX_W-1:0] UART_ARB_ID_BOOT  = 2'd2;
  localparam logic [UART_ARB_IDX_W-1:0] UART_ARB_ID_SPARE = 2'd3;

  typedef enum logic [UART_ARB_STATE_W-1:0] {
    UART_ARB_IDLE = 2'd0,
    UART_ARB_SEND = 2'd1,
    UART_ARB_HOLD = 2'd2
  } uart_arb_state_e;

  // Index of the set bit of a one-hot vector (0 when the vector is empty).
  function automatic logic [UART_ARB_IDX_W-1:0] onehot_to_idx(
    input logic [UART_ARB_REQ_NUM-1:0] oh
  );
    logic [UART_ARB_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < UART_ARB_REQ_NUM; i++) begin
      if (oh[i]) idx = UART_ARB_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/uart_arb_rr_pick.sv
// uart_arb_rr_pick
// Combinational round-robin picker. Scans the request vector starting at
// rr_ptr_i and wrapping around; the first set request wins.
// Ports:
//   req_i     [3:0]  pending requests
//   rr_ptr_i  [1:0]  highest-priority requester for this pick
//   winner_o  [3:0]  one-hot winner (0 when no request)
//   valid_o          at least one request is pending
module uart_arb_rr_pick
  import uart_arb_pkg::*;
(
  input  logic [UART_ARB_REQ_NUM-1:0] req_i,
  input  logic [UART_ARB_IDX_W-1:0]   rr_ptr_i,
  output logic [UART_ARB_REQ_NUM-1:0] winner_o,
  output logic                        valid_o
);

  logic [UART_ARB_IDX_W-1:0] idx;

  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    idx      = '0;
    for (int i = 0; i < UART_ARB_REQ_NUM; i++) begin
      // Index arithmetic wraps naturally because REQ_NUM is a power of two.
      idx = rr_ptr_i + UART_ARB_IDX_W'(i);
      if (!valid_o && req_i[idx]) begin
        winner_o[idx] = 1'b1;
        valid_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one uart_tx between four byte sources. Round-robin at byte
// granularity; a requester holding lock keeps ownership across bytes so
// multi-byte messages are not interleaved. Ownership is force-released after
// MAX_BURST bytes or after HOLD_TIMEOUT idle cycles in HOLD.
//
// Handshake: requester i raises req[i] with its byte on data[8i+7:8i] and
// holds both until ack[i] pulses for one cycle; the byte is transferred in
// that cycle. After ack it either drops req[i] or presents the next byte
// before the following tx_end. tx_start pulses with ack and tx_data stays
// stable until the next tx_start; tx_end closes the byte in flight.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   req, lock   [3:0]   per-requester request / keep-ownership
//   data        [31:0]  per-requester byte, requester i at [8i+7:8i]
//   ack, gnt    [3:0]   accept pulse / one-hot current owner
//   tx_start, tx_data   start pulse and byte to uart_tx
//   tx_busy, tx_end     uart_tx status and completion pulse
//   stat_cnt, stat_to   byte counters / timeout flags (UART_ARB_STAT_EN only)
//   dbg_state, dbg_rr_ptr  FSM state and round-robin pointer for observation
//
// Build option: define UART_ARB_STAT_EN to add the statistics outputs.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int REQ_NUM      = UART_ARB_REQ_NUM,
  parameter int MAX_BURST    = 16,
  parameter int HOLD_TIMEOUT = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [REQ_NUM-1:0]          req,
  input  logic [REQ_NUM-1:0]          lock,
  input  logic [8*REQ_NUM-1:0]        data,
  output logic [REQ_NUM-1:0]          ack,
  output logic [REQ_NUM-1:0]          gnt,
  output logic                        tx_start,
  output logic [7:0]                  tx_data,
  input  logic                        tx_busy,
  input  logic                        tx_end,
`ifdef UART_ARB_STAT_EN
  output logic [16*REQ_NUM-1:0]       stat_cnt,
  output logic [REQ_NUM-1:0]          stat_to,
`endif
  output logic [UART_ARB_STATE_W-1:0] dbg_state,
  output logic [UART_ARB_IDX_W-1:0]   dbg_rr_ptr
);

  uart_arb_state_e             state_q, state_d;
  logic [UART_ARB_IDX_W-1:0]   owner_q, owner_d;
  logic [UART_ARB_IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [UART_ARB_CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [UART_ARB_CNT_W-1:0]   hold_timer_q, hold_timer_d;
  logic [REQ_NUM-1:0]          gnt_q, gnt_d;
  logic [REQ_NUM-1:0]          ack_q, ack_d;
  logic                        tx_start_q, tx_start_d;
  logic [7:0]                  tx_data_q, tx_data_d;

  logic [REQ_NUM-1:0]          pick_oh;
  logic                        pick_valid;
  logic [UART_ARB_IDX_W-1:0]   pick_idx;

  uart_arb_rr_pick u_pick (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .winner_o (pick_oh),
    .valid_o  (pick_valid)
  );

  assign pick_idx = onehot_to_idx(pick_oh);

  // Decoded events. Only the owner's req/lock matter outside IDLE.
  logic below_cap, hold_expired;
  logic grant_idle, grant_hold, enter_hold, release_send, release_hold;
  logic timeout_rel;

  assign below_cap    = burst_cnt_q < UART_ARB_CNT_W'(MAX_BURST - 1);
  assign hold_expired = hold_timer_q == UART_ARB_CNT_W'(HOLD_TIMEOUT - 1);

  assign grant_idle   = (state_q == UART_ARB_IDLE) && pick_valid && !tx_busy;
  assign grant_hold   = (state_q == UART_ARB_HOLD) && req[owner_q];
  assign enter_hold   = (state_q == UART_ARB_SEND) && tx_end && lock[owner_q] && below_cap;
  assign release_send = (state_q == UART_ARB_SEND) && tx_end && !(lock[owner_q] && below_cap);
  assign release_hold = (state_q == UART_ARB_HOLD) && !req[owner_q]
                        && (!lock[owner_q] || hold_expired);
  // Release caused purely by the hold timer (owner still wanted the lock).
  assign timeout_rel  = (state_q == UART_ARB_HOLD) && !req[owner_q]
                        && lock[owner_q] && hold_expired;

  // State register (plus all registered datapath and outputs).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= UART_ARB_IDLE;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      burst_cnt_q  <= '0;
      hold_timer_q <= '0;
      gnt_q        <= '0;
      ack_q        <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      burst_cnt_q  <= burst_cnt_d;
      hold_timer_q <= hold_timer_d;
      gnt_q        <= gnt_d;
      ack_q        <= ack_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      UART_ARB_IDLE: if (grant_idle) state_d = UART_ARB_SEND;
      UART_ARB_SEND: begin
        if (enter_hold)        state_d = UART_ARB_HOLD;
        else if (release_send) state_d = UART_ARB_IDLE;
      end
      UART_ARB_HOLD: begin
        if (grant_hold)        state_d = UART_ARB_SEND;
        else if (release_hold) state_d = UART_ARB_IDLE;
      end
      default:                 state_d = UART_ARB_IDLE;
    endcase
  end

  // Output / datapath logic. ack and tx_start are pulses, so they default low.
  always_comb begin
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    burst_cnt_d  = burst_cnt_q;
    hold_timer_d = hold_timer_q;
    gnt_d        = gnt_q;
    ack_d        = '0;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    if (grant_idle) begin
      owner_d     = pick_idx;
      gnt_d       = pick_oh;
      ack_d       = pick_oh;
      tx_start_d  = 1'b1;
      tx_data_d   = data[{pick_idx, 3'b000} +: 8];
      burst_cnt_d = '0;
    end else if (grant_hold) begin
      ack_d       = gnt_q;
      tx_start_d  = 1'b1;
      tx_data_d   = data[{owner_q, 3'b000} +: 8];
      burst_cnt_d = burst_cnt_q + 8'd1;
    end else if (enter_hold) begin
      hold_timer_d = '0;
    end else if (release_send || release_hold) begin
      gnt_d    = '0;
      rr_ptr_d = owner_q + 1'b1;
    end else if (state_q == UART_ARB_HOLD) begin
      hold_timer_d = hold_timer_q + 8'd1;
    end
  end

  assign ack        = ack_q;
  assign gnt        = gnt_q;
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign dbg_state  = state_q;
  assign dbg_rr_ptr = rr_ptr_q;

`ifdef UART_ARB_STAT_EN
  logic [REQ_NUM-1:0][UART_ARB_STAT_W-1:0] stat_cnt_q;
  logic [REQ_NUM-1:0]                      stat_to_q;

  // Counters saturate at all-ones; timeout flags are sticky until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_cnt_q <= '0;
      stat_to_q  <= '0;
    end else begin
      for (int i = 0; i < REQ_NUM; i++) begin
        if (ack_d[i] && (stat_cnt_q[i] != 16'hFFFF)) begin
          stat_cnt_q[i] <= stat_cnt_q[i] + 16'd1;
        end
      end
      if (timeout_rel) stat_to_q[owner_q] <= 1'b1;
    end
  end

  assign stat_cnt = stat_cnt_q;
  assign stat_to  = stat_to_q;
`else
  // Timeout decode only feeds the statistics block.
  logic unused_timeout_rel;
  assign unused_timeout_rel = timeout_rel;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [3:0]  req, lock;
  logic [31:0] data;
  logic        tx_busy, tx_end;

  // Main instance: MAX_BURST=16, HOLD_TIMEOUT=8
  logic [3:0] m_ack, m_gnt;
  logic       m_start;
  logic [7:0] m_txd;
  logic [1:0] m_state, m_rr;
  // Burst-cap instance: MAX_BURST=4, HOLD_TIMEOUT=8
  logic [3:0] c_ack, c_gnt;
  logic       c_start;
  logic [7:0] c_txd;
  logic [1:0] c_state, c_rr;
`ifdef UART_ARB_STAT_EN
  logic [63:0] m_stat_cnt, c_stat_cnt;
  logic [3:0]  m_stat_to, c_stat_to;
`endif

  uart_tx_arbiter #(.MAX_BURST(16), .HOLD_TIMEOUT(8)) u_main (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .data(data),
    .ack(m_ack), .gnt(m_gnt), .tx_start(m_start), .tx_data(m_txd),
    .tx_busy(tx_busy), .tx_end(tx_end),
`ifdef UART_ARB_STAT_EN
    .stat_cnt(m_stat_cnt), .stat_to(m_stat_to),
`endif
    .dbg_state(m_state), .dbg_rr_ptr(m_rr)
  );

  uart_tx_arbiter #(.MAX_BURST(4), .HOLD_TIMEOUT(8)) u_cap (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .data(data),
    .ack(c_ack), .gnt(c_gnt), .tx_start(c_start), .tx_data(c_txd),
    .tx_busy(tx_busy), .tx_end(tx_end),
`ifdef UART_ARB_STAT_EN
    .stat_cnt(c_stat_cnt), .stat_to(c_stat_to),
`endif
    .dbg_state(c_state), .dbg_rr_ptr(c_rr)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks (called at negedge) ----------------
  task automatic cyc(input logic [3:0] r, input logic [3:0] l, input logic [31:0] d,
                     input logic b, input logic e);
    req = r; lock = l; data = d; tx_busy = b; tx_end = e;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    req = '0; lock = '0; data = '0; tx_busy = 1'b0; tx_end = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic [3:0]  req, lock;
    logic [31:0] data;
    logic        busy, tend;
    logic [3:0]  e_ack, e_gnt;
    logic        e_start;
    logic [7:0]  e_txd;
    logic [1:0]  e_state, e_rr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic [3:0] r, input logic [3:0] l,
                              input logic [31:0] d, input logic b, input logic e,
                              input logic [3:0] ea, input logic [3:0] eg, input logic es,
                              input logic [7:0] et, input logic [1:0] est, input logic [1:0] err);
    vec_t v;
    v.rst = rst; v.req = r; v.lock = l; v.data = d; v.busy = b; v.tend = e;
    v.e_ack = ea; v.e_gnt = eg; v.e_start = es; v.e_txd = et; v.e_state = est; v.e_rr = err;
    return v;
  endfunction

  localparam logic [1:0] ST_I = 2'd0;
  localparam logic [1:0] ST_S = 2'd1;
  localparam logic [1:0] ST_H = 2'd2;

  logic [31:0] d;
  logic [7:0]  msg [5];
  int          acks3;

  initial begin
    reset = 1'b1;
    req = '0; lock = '0; data = '0; tx_busy = 1'b0; tx_end = 1'b0;
    @(negedge clk);
    do_reset();

    d = 32'hD3C2_B1A0;
    // reset state
    vecs.push_back(mk(1, 4'h0, 4'h0, 32'h0,        0, 0, 4'h0, 4'h0, 0, 8'h00, ST_I, 2'd0));
    // single byte from requester 1
    vecs.push_back(mk(0, 4'h2, 4'h0, 32'h0000_4100, 0, 0, 4'h2, 4'h2, 1, 8'h41, ST_S, 2'd0));
    vecs.push_back(mk(0, 4'h0, 4'h0, 32'h0000_4100, 1, 0, 4'h0, 4'h2, 0, 8'h41, ST_S, 2'd0));
    vecs.push_back(mk(0, 4'h0, 4'h0, 32'h0000_4100, 0, 1, 4'h0, 4'h0, 0, 8'h41, ST_I, 2'd2));
    // tx_end in IDLE is ignored
    vecs.push_back(mk(0, 4'h0, 4'h0, 32'h0000_4100, 0, 1, 4'h0, 4'h0, 0, 8'h41, ST_I, 2'd2));
    vecs.push_back(mk(1, 4'h0, 4'h0, 32'h0,        0, 0, 4'h0, 4'h0, 0, 8'h00, ST_I, 2'd0));
    // round robin, all four requesting: order 0,1,2,3,0
    vecs.push_back(mk(0, 4'hF, 4'h0, d, 0, 0, 4'h1, 4'h1, 1, 8'hA0, ST_S, 2'd0));
    vecs.push_back(mk(0, 4'hF, 4'h0, d, 1, 0, 4'h0, 4'h1, 0, 8'hA0, ST_S, 2'd0));
    vecs.push_back(mk(0, 4'hF, 4'h0, d, 0, 1, 4'h0, 4'h0, 0, 8'hA0, ST_I, 2'd1));
    vecs.push_back(mk(0, 4'hF, 4'h0, d, 0, 0, 4'h2, 4'h2, 1, 8'hB1, ST_S, 2'd1));
    vecs.push_back(mk(0, 4'hF, 4'h0, d, 1, 0, 4'h0, 4'h2, 0, 8'hB1, ST_S, 2'd1));
    vecs.push_back(mk(0, 4'hF, 4'h0, d, 0, 1, 4'h0, 4'h0, 0, 8'hB1, ST_I, 2'd2));
    vecs.push_back(mk(0, 4'hF, 4'h0, d, 0, 0, 4'h4, 4'h4, 1, 8'hC2, ST_S, 2'd2));
    vecs.push_back(mk(0, 4'hF, 4'h0, d, 1, 0, 4'h0, 4'h4, 0, 8'hC2, ST_S, 2'd2));
    vecs.push_back(mk(0, 4'hF, 4'h0, d, 0, 1, 4'h0, 4'h0, 0, 8'hC2, ST_I, 2'd3));
    vecs.push_back(mk(0, 4'hF, 4'h0, d, 0, 0, 4'h8, 4'h8, 1, 8'hD3, ST_S, 2'd3));
    vecs.push_back(mk(0, 4'hF, 4'h0, d, 1, 0, 4'h0, 4'h8, 0, 8'hD3, ST_S, 2'd3));
    vecs.push_back(mk(0, 4'hF, 4'h0, d, 0, 1, 4'h0, 4'h0, 0, 8'hD3, ST_I, 2'd0));
    vecs.push_back(mk(0, 4'hF, 4'h0, d, 0, 0, 4'h1, 4'h1, 1, 8'hA0, ST_S, 2'd0));
    vecs.push_back(mk(0, 4'hF, 4'h0, d, 1, 0, 4'h0, 4'h1, 0, 8'hA0, ST_S, 2'd0));
    vecs.push_back(mk(0, 4'hF, 4'h0, d, 0, 1, 4'h0, 4'h0, 0, 8'hA0, ST_I, 2'd1));
    // requester 1 locks, enters HOLD, other requester not served, lock drop releases
    vecs.push_back(mk(0, 4'h2, 4'h2, d, 0, 0, 4'h2, 4'h2, 1, 8'hB1, ST_S, 2'd1));
    vecs.push_back(mk(0, 4'h0, 4'h2, d, 1, 0, 4'h0, 4'h2, 0, 8'hB1, ST_S, 2'd1));
    vecs.push_back(mk(0, 4'h0, 4'h2, d, 0, 1, 4'h0, 4'h2, 0, 8'hB1, ST_H, 2'd1));
    vecs.push_back(mk(0, 4'h8, 4'h2, d, 0, 0, 4'h0, 4'h2, 0, 8'hB1, ST_H, 2'd1));
    vecs.push_back(mk(0, 4'h8, 4'h0, d, 0, 0, 4'h0, 4'h0, 0, 8'hB1, ST_I, 2'd2));
    vecs.push_back(mk(0, 4'h8, 4'h0, d, 0, 0, 4'h8, 4'h8, 1, 8'hD3, ST_S, 2'd2));
    vecs.push_back(mk(0, 4'h0, 4'h0, d, 0, 1, 4'h0, 4'h0, 0, 8'hD3, ST_I, 2'd0));

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst;
      cyc(vecs[i].req, vecs[i].lock, vecs[i].data, vecs[i].busy, vecs[i].tend);
      check($sformatf("vec%0d.ack", i),   32'(m_ack),   32'(vecs[i].e_ack));
      check($sformatf("vec%0d.gnt", i),   32'(m_gnt),   32'(vecs[i].e_gnt));
      check($sformatf("vec%0d.start", i), 32'(m_start), 32'(vecs[i].e_start));
      check($sformatf("vec%0d.txd", i),   32'(m_txd),   32'(vecs[i].e_txd));
      check($sformatf("vec%0d.state", i), 32'(m_state), 32'(vecs[i].e_state));
      check($sformatf("vec%0d.rr", i),    32'(m_rr),    32'(vecs[i].e_rr));
    end
    reset = 1'b0;

    // ---------- locked burst "HELLO" from requester 2, requester 0 waiting ----------
    do_reset();
    msg[0] = 8'h48; msg[1] = 8'h45; msg[2] = 8'h4C; msg[3] = 8'h4C; msg[4] = 8'h4F;
    d = {8'h00, msg[0], 8'h00, 8'h30};
    cyc(4'b0100, 4'b0100, d, 0, 0);
    check("hello0.ack", 32'(m_ack), 32'h4);
    check("hello0.txd", 32'(m_txd), 32'h48);
    for (int k = 1; k < 5; k++) begin
      d[23:16] = msg[k];
      cyc(4'b0101, 4'b0100, d, 1, 0);
      cyc(4'b0101, 4'b0100, d, 0, 1);
      check($sformatf("hello%0d.hold", k), 32'(m_state), 32'(ST_H));
      check($sformatf("hello%0d.gnt", k),  32'(m_gnt),   32'h4);
      cyc(4'b0101, 4'b0100, d, 0, 0);
      check($sformatf("hello%0d.ack", k),   32'(m_ack),   32'h4);
      check($sformatf("hello%0d.start", k), 32'(m_start), 32'h1);
      check($sformatf("hello%0d.txd", k),   32'(m_txd),   32'(msg[k]));
    end
    cyc(4'b0001, 4'b0000, d, 1, 0);
    cyc(4'b0001, 4'b0000, d, 0, 1);
    check("hello.release_gnt", 32'(m_gnt), 32'h0);
    cyc(4'b0001, 4'b0000, d, 0, 0);
    check("hello.next_ack", 32'(m_ack), 32'h1);
    check("hello.next_txd", 32'(m_txd), 32'h30);

    // ---------- burst cap (MAX_BURST=4 instance) ----------
    do_reset();
    acks3 = 0;
    d = {8'hC0, 16'h0000, 8'h30};
    for (int k = 0; k < 4; k++) begin
      cyc((k == 0) ? 4'b1000 : 4'b1001, 4'b1000, d, 0, 0);
      acks3 += int'(c_ack[3]);
      check($sformatf("cap%0d.ack", k), 32'(c_ack), 32'h8);
      check($sformatf("cap%0d.txd", k), 32'(c_txd), 32'hC0 + 32'(k));
      d[31:24] = d[31:24] + 8'd1;
      cyc(4'b1001, 4'b1000, d, 1, 0);
      acks3 += int'(c_ack[3]);
      cyc(4'b1001, 4'b1000, d, 0, 1);
      acks3 += int'(c_ack[3]);
      check($sformatf("cap%0d.state", k), 32'(c_state), (k < 3) ? 32'(ST_H) : 32'(ST_I));
    end
    check("cap.release_gnt", 32'(c_gnt), 32'h0);
    cyc(4'b1001, 4'b1000, d, 0, 0);
    acks3 += int'(c_ack[3]);
    check("cap.next_ack", 32'(c_ack), 32'h1);
    check("cap.next_gnt", 32'(c_gnt), 32'h1);
    check("cap.acks_req3", 32'(acks3), 32'd4);

    // ---------- hold timeout (HOLD_TIMEOUT=8) ----------
    do_reset();
    d = 32'h0000_5A00;
    cyc(4'b0010, 4'b0010, d, 0, 0);
    check("to.ack", 32'(m_ack), 32'h2);
    cyc(4'b0000, 4'b0010, d, 1, 0);
    cyc(4'b0000, 4'b0010, d, 0, 1);
    check("to.enter_hold", 32'(m_state), 32'(ST_H));
    repeat (7) cyc(4'b0000, 4'b0010, d, 0, 0);
    check("to.still_hold", 32'(m_state), 32'(ST_H));
    check("to.still_gnt",  32'(m_gnt),   32'h2);
    cyc(4'b0000, 4'b0010, d, 0, 0);
    check("to.released", 32'(m_state), 32'(ST_I));
    check("to.gnt",      32'(m_gnt),   32'h0);
    check("to.rr",       32'(m_rr),    32'd2);
`ifdef UART_ARB_STAT_EN
    check("to.stat_to",  32'(m_stat_to),        32'h2);
    check("to.stat_cnt", 32'(m_stat_cnt[31:16]), 32'd1);
    check("to.stat_cnt0", 32'(m_stat_cnt[15:0]), 32'd0);
`endif

    // ---------- reset mid-SEND, then tx_busy gating ----------
    do_reset();
    d = 32'h0000_0077;
    cyc(4'b0001, 4'b0000, d, 0, 0);
    check("rst.pre_start", 32'(m_start), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("rst.ack",   32'(m_ack),   32'h0);
    check("rst.gnt",   32'(m_gnt),   32'h0);
    check("rst.start", 32'(m_start), 32'h0);
    check("rst.txd",   32'(m_txd),   32'h0);
    check("rst.state", 32'(m_state), 32'(ST_I));
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc(4'b0001, 4'b0000, d, 1, 0);
      check($sformatf("busy%0d.start", k), 32'(m_start), 32'h0);
      check($sformatf("busy%0d.gnt", k),   32'(m_gnt),   32'h0);
    end
    cyc(4'b0001, 4'b0000, d, 0, 0);
    check("busy.fall_start", 32'(m_start), 32'h1);
    check("busy.fall_ack",   32'(m_ack),   32'h1);
    check("busy.fall_txd",   32'(m_txd),   32'h77);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
